// File: rtl/vga_sync_decoder.sv
`timescale 1ns/1ps
// vga_sync_decoder: locks onto a 640x480@60 sync stream sampled at Clk50 and emits one strobe per active pixel.
// Optional macro VGA_DEC_SUPERPIX_EN adds the registered 32x32 super-pixel index (SuperX/SuperY).
//
// state  | meaning
// SEARCH | no timing known, wait for any HSync fall
// HMEAS  | measuring one H period
// VWAIT  | H period good, waiting for the first line of a frame
// LOCKED | decoding pixels, checking H period, sync presence and line count
module vga_sync_decoder #(
  parameter int V_TOTAL  = 525,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic       Clk50,
  input  logic       Reset,
  input  logic       HSync,
  input  logic       VSync,
  input  logic       R,
  input  logic       G,
  input  logic       B,
  output logic [9:0] Col,
  output logic [8:0] Row,
  output logic       PixValid,
  output logic       PixR,
  output logic       PixG,
  output logic       PixB,
  output logic [4:0] SuperX,
  output logic [3:0] SuperY,
  output logic       Locked,
  output logic       LockErr,
  output logic       FrameStart
);

  typedef enum logic [1:0] {SEARCH, HMEAS, VWAIT, LOCKED} state_t;

  localparam logic [10:0] H_MAX       = 11'd2047;
  localparam logic [10:0] PER_MIN     = 11'd1598;
  localparam logic [10:0] PER_MAX     = 11'd1602;
  localparam logic [10:0] H_ACT_FIRST = 11'd288;
  localparam logic [10:0] H_ACT_LAST  = 11'd1567;
  localparam logic [9:0]  L_MAX       = 10'd1023;
  localparam logic [9:0]  V_FIRST     = 10'(V_START);
  localparam logic [9:0]  V_LAST      = 10'(V_START + V_ACTIVE - 1);
  localparam logic [9:0]  V_END       = 10'(V_TOTAL - 1);

  logic        hs_q, hs_d, vs_q, vs_d, r_q, g_q, b_q;
  logic        hs_fall, vs_fall, v_pend, line_clr;
  logic [10:0] h_reg, h;
  logic [9:0]  l_cnt;
  logic        period_ok, sync_lost, h_act, v_act, strobe, lock_fail;
  logic [9:0]  col_next;
  logic [8:0]  row_next;
  state_t      state, state_next;

  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      hs_q <= 1'b1;
      hs_d <= 1'b1;
      vs_q <= 1'b1;
      vs_d <= 1'b1;
      r_q  <= 1'b0;
      g_q  <= 1'b0;
      b_q  <= 1'b0;
    end else begin
      hs_q <= HSync;
      hs_d <= hs_q;
      vs_q <= VSync;
      vs_d <= vs_q;
      r_q  <= R;
      g_q  <= G;
      b_q  <= B;
    end
  end

  assign hs_fall  = hs_d & ~hs_q;
  assign vs_fall  = vs_d & ~vs_q;
  assign line_clr = hs_fall & (vs_fall | v_pend);

  // h reads 0 on the fall cycle itself, so h_reg there still holds the full period just ended
  assign h         = hs_fall ? 11'd0 : h_reg;
  assign period_ok = (h_reg >= PER_MIN) && (h_reg <= PER_MAX);
  assign sync_lost = !hs_fall && (h_reg == H_MAX);

  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      h_reg  <= 11'd0;
      l_cnt  <= 10'd0;
      v_pend <= 1'b0;
    end else begin
      if (hs_fall)
        h_reg <= 11'd1;
      else if (h_reg != H_MAX)
        h_reg <= h_reg + 11'd1;

      if (line_clr)
        v_pend <= 1'b0;
      else if (vs_fall)
        v_pend <= 1'b1;

      if (line_clr)
        l_cnt <= 10'd0;
      else if (hs_fall && (l_cnt != L_MAX))
        l_cnt <= l_cnt + 10'd1;
    end
  end

  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset)
      state <= SEARCH;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    lock_fail  = 1'b0;
    case (state)
      SEARCH: if (hs_fall) state_next = HMEAS;
      HMEAS:  if (hs_fall && period_ok) state_next = VWAIT;
      VWAIT: begin
        if (hs_fall && !period_ok)
          state_next = SEARCH;
        else if (line_clr)
          state_next = LOCKED;
      end
      LOCKED: begin
        // at a frame boundary the last line of the frame is numbered V_TOTAL-1
        if ((hs_fall && !period_ok) || sync_lost || (line_clr && (l_cnt != V_END))) begin
          lock_fail  = 1'b1;
          state_next = SEARCH;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    Locked = (state == LOCKED);
  end

  assign h_act    = (h >= H_ACT_FIRST) && (h <= H_ACT_LAST);
  assign v_act    = (l_cnt >= V_FIRST) && (l_cnt <= V_LAST);
  assign strobe   = h[0] && h_act && v_act && (state == LOCKED);
  assign col_next = h[10:1] - 10'd144;
  assign row_next = 9'(l_cnt - V_FIRST);

  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      PixValid   <= 1'b0;
      LockErr    <= 1'b0;
      FrameStart <= 1'b0;
      Col        <= 10'd0;
      Row        <= 9'd0;
      PixR       <= 1'b0;
      PixG       <= 1'b0;
      PixB       <= 1'b0;
    end else begin
      PixValid   <= strobe;
      LockErr    <= lock_fail;
      FrameStart <= strobe && (col_next == 10'd0) && (row_next == 9'd0);
      if (strobe) begin
        Col  <= col_next;
        Row  <= row_next;
        PixR <= r_q;
        PixG <= g_q;
        PixB <= b_q;
      end
    end
  end

`ifdef VGA_DEC_SUPERPIX_EN
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      SuperX <= 5'd0;
      SuperY <= 4'd0;
    end else if (strobe) begin
      SuperX <= col_next[9:5];
      SuperY <= row_next[8:5];
    end
  end
`else
  assign SuperX = 5'd0;
  assign SuperY = 4'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns/1ps
// tb_vga_sync_decoder: drives a full-width VGA line stream with a shortened frame height and
// scores every pixel strobe against an expected-pixel queue.
module tb_vga_sync_decoder;

  localparam int VT = 5;
  localparam int VS = 1;
  localparam int VA = 4;
  localparam int LINE = 1600;

  logic       Clk50 = 1'b0;
  logic       Reset, HSync, VSync, R, G, B;
  logic [9:0] Col;
  logic [8:0] Row;
  logic       PixValid, PixR, PixG, PixB, Locked, LockErr, FrameStart;
  logic [4:0] SuperX;
  logic [3:0] SuperY;

  vga_sync_decoder #(.V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA)) dut (
    .Clk50(Clk50), .Reset(Reset), .HSync(HSync), .VSync(VSync),
    .R(R), .G(G), .B(B),
    .Col(Col), .Row(Row), .PixValid(PixValid),
    .PixR(PixR), .PixG(PixG), .PixB(PixB),
    .SuperX(SuperX), .SuperY(SuperY),
    .Locked(Locked), .LockErr(LockErr), .FrameStart(FrameStart)
  );

  always #10 Clk50 = ~Clk50;

  typedef struct packed {
    logic [9:0] col;
    logic [8:0] row;
    logic       r;
    logic       g;
    logic       b;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   line_cyc = 0;
  int   err_cyc = -1;
  int   n_strobe = 0, n_fs = 0, n_r = 0, n_err = 0;
  logic [4:0] exp_sx;
  logic [3:0] exp_sy;
  logic       exp_fs;

  always @(posedge Clk50) cyc <= cyc + 1;

  // scoreboard consumer: every strobe must match the oldest expected pixel
  always @(negedge Clk50) begin
    if (LockErr) begin
      n_err++;
      err_cyc = cyc;
    end
    if (PixValid) begin
      n_strobe++;
      if (PixR) n_r++;
      if (FrameStart) n_fs++;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected got col=%0d row=%0d, want no strobe", Col, Row);
      end else begin
        e = q.pop_front();
`ifdef VGA_DEC_SUPERPIX_EN
        exp_sx = e.col[9:5];
        exp_sy = e.row[8:5];
`else
        exp_sx = 5'd0;
        exp_sy = 4'd0;
`endif
        exp_fs = (e.col == 10'd0) && (e.row == 9'd0);
        if ({Col, Row, PixR, PixG, PixB, SuperX, SuperY, FrameStart} !==
            {e.col, e.row, e.r, e.g, e.b, exp_sx, exp_sy, exp_fs}) begin
          miscompares++;
          $display("FAIL pixel got col=%0d row=%0d rgb=%b%b%b sx=%0d sy=%0d fs=%b, want col=%0d row=%0d rgb=%b%b%b sx=%0d sy=%0d fs=%b",
                   Col, Row, PixR, PixG, PixB, SuperX, SuperY, FrameStart,
                   e.col, e.row, e.r, e.g, e.b, exp_sx, exp_sy, exp_fs);
        end
      end
    end else if (FrameStart) begin
      vectors++;
      miscompares++;
      $display("FAIL framestart_without_strobe got FrameStart=1, want 0");
    end
  end

  task automatic drive_line(input int line, input int k0, input int k1, input bit lock);
    for (int k = k0; k < k1; k++) begin
      int   m;
      int   col;
      int   row;
      logic act;
      @(negedge Clk50);
      if (k == 0) line_cyc = cyc;
      m   = k / 2;
      col = m - 144;
      row = line - VS;
      act = (m >= 144) && (m <= 783) && (line >= VS) && (line < VS + VA);
      HSync = (k < 192) ? 1'b0 : 1'b1;
      VSync = (line == 0) ? 1'b0 : 1'b1;
      R = act && (row == 3) && (col >= 32) && (col <= 63);
      G = act && (col % 7 == 0);
      B = act && (row % 2 == 1);
      if (lock && act && (k % 2 == 1))
        q.push_back('{col: 10'(col), row: 9'(row), r: R, g: G, b: B});
    end
  endtask

  task automatic drive_frame(input bit lock);
    for (int l = 0; l < VT; l++) drive_line(l, 0, LINE, lock);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge Clk50);
    vectors++;
    if ({Col, Row, PixValid, PixR, PixG, PixB, SuperX, SuperY, Locked, LockErr, FrameStart} !== 34'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got col=%0d row=%0d pv=%b lk=%b le=%b fs=%b, want all 0",
               Col, Row, PixValid, Locked, LockErr, FrameStart);
    end
    vectors++;
    if ({dut.h_reg, dut.l_cnt} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_counters got h=%0d L=%0d, want 0 0", dut.h_reg, dut.l_cnt);
    end
    Reset = 1'b0;
  endtask

  task automatic test_lock_acquire;
    int s0, f0, r0;
    s0 = n_strobe; f0 = n_fs; r0 = n_r;
    drive_frame(1'b0);
    vectors++;
    if (Locked !== 1'b0 || n_strobe != s0) begin
      miscompares++;
      $display("FAIL frame1_unlocked got Locked=%b strobes=%0d, want 0 0", Locked, n_strobe - s0);
    end
    drive_line(0, 0, 4, 1'b1);
    vectors++;
    if (Locked !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_at_frame2 got Locked=%b, want 1", Locked);
    end
    drive_line(0, 4, LINE, 1'b1);
    for (int l = 1; l < VT; l++) drive_line(l, 0, LINE, 1'b1);
    vectors++;
    if (n_strobe - s0 != VA * 640) begin
      miscompares++;
      $display("FAIL frame2_strobes got %0d, want %0d", n_strobe - s0, VA * 640);
    end
    vectors++;
    if (n_fs - f0 != 1) begin
      miscompares++;
      $display("FAIL frame2_framestart got %0d, want 1", n_fs - f0);
    end
    vectors++;
    if (n_r - r0 != 32) begin
      miscompares++;
      $display("FAIL red_band_count got %0d, want 32", n_r - r0);
    end
    vectors++;
    if (Col !== 10'd639 || Row !== 9'(VA - 1) || Locked !== 1'b1 || n_err != 0) begin
      miscompares++;
      $display("FAIL hold_after_frame got col=%0d row=%0d lk=%b errs=%0d, want 639 %0d 1 0",
               Col, Row, Locked, n_err, VA - 1);
    end
  endtask

  task automatic test_stretch;
    int s0, e0;
    e0 = n_err;
    drive_line(0, 0, 4, 1'b1);
    vectors++;
    if (Locked !== 1'b1 || n_err != e0) begin
      miscompares++;
      $display("FAIL frame_count_check got Locked=%b errs=%0d, want 1 0", Locked, n_err - e0);
    end
    s0 = n_strobe;
    drive_line(0, 4, 1610, 1'b1);
    for (int l = 1; l < VT; l++) drive_line(l, 0, LINE, 1'b0);
    vectors++;
    if (n_err - e0 != 1 || Locked !== 1'b0 || n_strobe != s0) begin
      miscompares++;
      $display("FAIL stretched_line got errs=%0d Locked=%b strobes=%0d, want 1 0 0",
               n_err - e0, Locked, n_strobe - s0);
    end
    s0 = n_strobe;
    drive_frame(1'b1);
    vectors++;
    if (n_strobe - s0 != VA * 640 || Locked !== 1'b1 || n_err - e0 != 1) begin
      miscompares++;
      $display("FAIL relock_after_stretch got strobes=%0d Locked=%b errs=%0d, want %0d 1 1",
               n_strobe - s0, Locked, n_err - e0, VA * 640);
    end
  endtask

  task automatic test_hsync_hold;
    int e0;
    e0 = n_err;
    drive_line(0, 0, 3000, 1'b1);
    vectors++;
    if (n_err - e0 != 1 || err_cyc != line_cyc + 2049) begin
      miscompares++;
      $display("FAIL sync_lost_pulse got errs=%0d at +%0d cycles, want 1 at +2049",
               n_err - e0, err_cyc - line_cyc);
    end
    vectors++;
    if (dut.h_reg !== 11'd2047 || Locked !== 1'b0) begin
      miscompares++;
      $display("FAIL h_saturate got h=%0d Locked=%b, want 2047 0", dut.h_reg, Locked);
    end
    for (int l = 1; l < VT; l++) drive_line(l, 0, LINE, 1'b0);
  endtask

  task automatic test_reset_midframe;
    int s0, f0;
    drive_line(0, 0, LINE, 1'b1);
    drive_line(1, 0, LINE, 1'b1);
    drive_line(2, 0, 2 * (144 + 300) + 3, 1'b1);
    @(negedge Clk50);
    vectors++;
    if (Col !== 10'd300 || Row !== 9'd1 || Locked !== 1'b1) begin
      miscompares++;
      $display("FAIL before_reset got col=%0d row=%0d Locked=%b, want 300 1 1", Col, Row, Locked);
    end
    #2 Reset = 1'b1;
    #1;
    vectors++;
    if ({Col, Row, PixValid, PixR, PixG, PixB, SuperX, SuperY, Locked, LockErr, FrameStart} !== 34'd0) begin
      miscompares++;
      $display("FAIL async_reset got col=%0d row=%0d pv=%b lk=%b, want all 0", Col, Row, PixValid, Locked);
    end
    repeat (2) @(negedge Clk50);
    Reset = 1'b0;
    drive_line(2, 900, LINE, 1'b0);
    for (int l = 3; l < VT; l++) drive_line(l, 0, LINE, 1'b0);
    vectors++;
    if (Locked !== 1'b0) begin
      miscompares++;
      $display("FAIL no_early_relock got Locked=%b, want 0", Locked);
    end
    s0 = n_strobe; f0 = n_fs;
    drive_frame(1'b1);
    vectors++;
    if (n_strobe - s0 != VA * 640 || n_fs - f0 != 1 || Locked !== 1'b1) begin
      miscompares++;
      $display("FAIL relock_after_reset got strobes=%0d fs=%0d Locked=%b, want %0d 1 1",
               n_strobe - s0, n_fs - f0, Locked, VA * 640);
    end
  endtask

  initial begin
    Reset = 1'b1;
    HSync = 1'b1;
    VSync = 1'b1;
    R = 1'b0;
    G = 1'b0;
    B = 1'b0;
    test_reset();
    test_lock_acquire();
    test_stretch();
    test_hsync_hold();
    test_reset_midframe();
    repeat (4) @(negedge Clk50);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
